apple2_bus_seq: RTL



---
 rtl/gr8ram_pkg.sv | 20 ++
 rtl/bus_sel_sampler.sv | 82 ++++++++
 rtl/apple2_bus_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gr8ram_pkg.sv
// Shared constants for the GR8RAM card logic: bus-cycle state numbers,
// default refresh period and the $CFFF slot-ROM release address.
package gr8ram_pkg;

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_PHI1          = 3'd1;
  localparam logic [2:0] S_SAMPLE_IOSTRB = 3'd3;
  localparam logic [2:0] S_SAMPLE        = 3'd4;
  localparam logic [2:0] S_LAST          = 3'd7;

  localparam int unsigned REF_PERIOD_DEF = 13;

  localparam logic [10:0] CFFF_ADDR = 11'h7FF;

  // True in S4 and S5, where the slot selects and R/W are stable.
  function automatic logic in_sample_win(input logic [2:0] s);
    return (s == S_SAMPLE) || (s == S_SAMPLE + 3'd1);
  endfunction

endpackage

// File: rtl/bus_sel_sampler.sv
// Captures the slot selects and R/W inside their legal windows and holds them
// until the next bus cycle starts; also produces the one-C7M $CFFF pulse.
module bus_sel_sampler
  import gr8ram_pkg::*;
(
  input  logic        C7M,
  input  logic        nRES,
  input  logic [2:0]  s,
  input  logic        sync,
  input  logic        clr,
  input  logic        nDEVSEL,
  input  logic        nIOSEL,
  input  logic        nIOSTRB,
  input  logic        nWE,
  input  logic [10:0] A11,
  output logic        DevSel,
  output logic        IoSel,
  output logic        IoStrb,
  output logic        WrCyc,
  output logic        CFFFHit
);

  logic dev_sel_q, dev_sel_d;
  logic io_sel_q, io_sel_d;
  logic io_strb_q, io_strb_d;
  logic wr_cyc_q, wr_cyc_d;
  logic cfff_hit_q, cfff_hit_d;

  logic win_main;
  logic win_strb;
  logic any_sel;

  always_comb begin
    win_main = in_sample_win(s);
    win_strb = win_main || (s == S_SAMPLE_IOSTRB);
    any_sel  = ~nDEVSEL | ~nIOSEL | ~nIOSTRB;

    dev_sel_d  = dev_sel_q;
    io_sel_d   = io_sel_q;
    io_strb_d  = io_strb_q;
    wr_cyc_d   = wr_cyc_q;
    cfff_hit_d = 1'b0;

    // A new bus cycle (or loss of sync) wins over any set condition.
    if (sync || clr) begin
      dev_sel_d = 1'b0;
      io_sel_d  = 1'b0;
      io_strb_d = 1'b0;
      wr_cyc_d  = 1'b0;
    end else begin
      if (win_main && !nDEVSEL)          dev_sel_d = 1'b1;
      if (win_main && !nIOSEL)           io_sel_d  = 1'b1;
      if (win_strb && !nIOSTRB)          io_strb_d = 1'b1;
      if (win_main && !nWE && any_sel)   wr_cyc_d  = 1'b1;
    end

    if (!clr && (s == S_SAMPLE) && !nIOSTRB && (A11 == CFFF_ADDR)) cfff_hit_d = 1'b1;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      dev_sel_q  <= 1'b0;
      io_sel_q   <= 1'b0;
      io_strb_q  <= 1'b0;
      wr_cyc_q   <= 1'b0;
      cfff_hit_q <= 1'b0;
    end else begin
      dev_sel_q  <= dev_sel_d;
      io_sel_q   <= io_sel_d;
      io_strb_q  <= io_strb_d;
      wr_cyc_q   <= wr_cyc_d;
      cfff_hit_q <= cfff_hit_d;
    end
  end

  assign DevSel  = dev_sel_q;
  assign IoSel   = io_sel_q;
  assign IoStrb  = io_strb_q;
  assign WrCyc   = wr_cyc_q;
  assign CFFFHit = cfff_hit_q;

endmodule

// File: rtl/apple2_bus_seq.sv
// Apple II bus-cycle sequencer: locks to delayed PHI1, counts C7M into S1..S7,
// schedules refresh. Optional sync-loss watchdog built when SYNC_WDT_EN is defined.
module apple2_bus_seq
  import gr8ram_pkg::*;
#(
  parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
  parameter int unsigned WDT_LIMIT  = 15
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        PHI1,
  input  logic        nDEVSEL,
  input  logic        nIOSEL,
  input  logic        nIOSTRB,
  input  logic        nWE,
  input  logic [10:0] A11,
  output logic [2:0]  S,
  output logic        RefNow,
  output logic        DevSel,
  output logic        IoSel,
  output logic        IoStrb,
  output logic        WrCyc,
  output logic        CFFFHit,
  output logic        Synced
);

  if ((REF_PERIOD < 2) || (REF_PERIOD > 16)) begin : g_bad_ref_period
    $error("REF_PERIOD must be in 2..16");
  end
  if ((WDT_LIMIT < 2) || (WDT_LIMIT > 15)) begin : g_bad_wdt_limit
    $error("WDT_LIMIT must be in 2..15");
  end

  localparam logic [3:0] RefLast = 4'(REF_PERIOD - 1);

  logic [2:0] s_q, s_d;
  logic [3:0] ref_q, ref_d;
  logic       phi1r_q;
  logic       phi0seen_q, phi0seen_d;
  logic       synced_q, synced_d;
  logic       sync;
  logic       wdt_fire;

  assign sync = PHI1 & ~phi1r_q & phi0seen_q;

`ifdef SYNC_WDT_EN
  localparam logic [3:0] WdtTerm = 4'(WDT_LIMIT - 1);

  logic [3:0] wdt_q, wdt_d;

  // Fires on the edge where the count would reach WDT_LIMIT.
  assign wdt_fire = synced_q & ~sync & (wdt_q == WdtTerm);

  always_comb begin
    wdt_d = wdt_q;
    if (sync) begin
      wdt_d = 4'd0;
    end else if (synced_q && (wdt_q != 4'hF)) begin
      wdt_d = wdt_q + 4'd1;
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      wdt_q <= 4'd0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif

  always_comb begin
    s_d        = s_q;
    ref_d      = ref_q;
    phi0seen_d = phi0seen_q;
    synced_d   = synced_q;

    if (wdt_fire) begin
      s_d = S_IDLE;
    end else if (sync) begin
      s_d = S_PHI1;
    end else if ((s_q == S_IDLE) || (s_q == S_LAST)) begin
      s_d = s_q;
    end else begin
      s_d = s_q + 3'd1;
    end

    if (s_q == S_SAMPLE_IOSTRB) begin
      ref_d = (ref_q == RefLast) ? 4'd0 : ref_q + 4'd1;
    end

    if (wdt_fire) begin
      phi0seen_d = 1'b0;
    end else if (!PHI1) begin
      phi0seen_d = 1'b1;
    end

    if (wdt_fire) begin
      synced_d = 1'b0;
    end else if (sync) begin
      synced_d = 1'b1;
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      s_q        <= S_IDLE;
      ref_q      <= 4'd0;
      phi1r_q    <= 1'b0;
      phi0seen_q <= 1'b0;
      synced_q   <= 1'b0;
    end else begin
      s_q        <= s_d;
      ref_q      <= ref_d;
      phi1r_q    <= PHI1;
      phi0seen_q <= phi0seen_d;
      synced_q   <= synced_d;
    end
  end

  bus_sel_sampler u_sampler (
    .C7M     (C7M),
    .nRES    (nRES),
    .s       (s_q),
    .sync    (sync),
    .clr     (wdt_fire),
    .nDEVSEL (nDEVSEL),
    .nIOSEL  (nIOSEL),
    .nIOSTRB (nIOSTRB),
    .nWE     (nWE),
    .A11     (A11),
    .DevSel  (DevSel),
    .IoSel   (IoSel),
    .IoStrb  (IoStrb),
    .WrCyc   (WrCyc),
    .CFFFHit (CFFFHit)
  );

  assign S      = s_q;
  assign RefNow = (s_q == S_PHI1) && (ref_q == 4'd0);
  assign Synced = synced_q;

endmodule
